ucsbece154b_fetch_unit: RTL and testbench

//  Instruction-fetch stage plus IF/ID register feeding the decode stage and pipeline controller.

---
 rtl/ucsbece154b_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_ucsbece154b_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_fetch_unit.sv
// Instruction-fetch stage and IF/ID register.
// Issues PC-ordered requests to a variable-latency instruction memory, tags each
// request with the current epoch, buffers fresh responses in a small fetch queue
// and feeds decode through the IF/ID register under StallD/FlushD/PCSrcE control.
//
// Handshake semantics: a request transfers on every rising edge where
// ImemReqValid_o and ImemReqReady_i are both high; ImemReqAddr_o is meaningful
// only while ImemReqValid_o is high. The memory returns exactly one
// ImemRespValid_i beat per transferred request, in request order, with no
// backpressure from this block.
module ucsbece154b_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH  = 2,   // power of two, at least 2
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        ImemReqValid_o,
  input  logic        ImemReqReady_i,
  output logic [31:0] ImemReqAddr_o,
  input  logic        ImemRespValid_i,
  input  logic [31:0] ImemRespData_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o,
  output logic        FetchEmpty_o
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] DEPTH_N = FQ_DEPTH[CW-1:0];
  localparam logic [CW:0]   DEPTH_W = FQ_DEPTH[CW:0];

  // Fetch-side state
  logic [31:0]   pcF;
  logic          epoch;
  logic [CW-1:0] outstanding;

  // Tag FIFO: PC and epoch of every request still awaiting its response
  logic [31:0]   tagPc    [FQ_DEPTH];
  logic          tagEpoch [FQ_DEPTH];
  logic [PW-1:0] tagWr;
  logic [PW-1:0] tagRd;

  // Fetch queue: returned words waiting for the IF/ID register
  logic [31:0]   fqData [FQ_DEPTH];
  logic [31:0]   fqPc   [FQ_DEPTH];
  logic [PW-1:0] fqWr;
  logic [PW-1:0] fqRd;
  logic [CW-1:0] fqCount;

  logic [CW:0] slotsInUse;
  logic        reqAccept;
  logic        respTake;
  logic        respFresh;
  logic        fqEmpty;
  logic        fqFull;
  logic        bubbleD;
  logic        fqPop;

  // Every buffered or in-flight word holds a slot, so a fresh response always fits.
  assign slotsInUse     = {1'b0, outstanding} + {1'b0, fqCount};
  assign ImemReqValid_o = reset & ~StallF_i & ~PCSrcE_i & (slotsInUse < DEPTH_W);
  assign ImemReqAddr_o  = pcF;
  assign reqAccept      = ImemReqValid_o & ImemReqReady_i;

  // A response with nothing outstanding (e.g. issued before a reset) is ignored.
  assign respTake  = ImemRespValid_i & (outstanding != '0);
  assign respFresh = respTake & (tagEpoch[tagRd] == epoch) & ~PCSrcE_i;

  assign fqEmpty      = (fqCount == '0);
  assign fqFull       = (fqCount == DEPTH_N);
  assign FetchEmpty_o = fqEmpty;

  assign bubbleD = FlushD_i | PCSrcE_i;
  assign fqPop   = ~bubbleD & ~StallD_i & ~fqEmpty;

  // PC, epoch, outstanding count and tag FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF         <= RESET_PC;
      epoch       <= 1'b0;
      outstanding <= '0;
      tagWr       <= '0;
      tagRd       <= '0;
    end else begin
      if (PCSrcE_i) begin
        pcF   <= PCTargetE_i;
        epoch <= ~epoch;
      end else if (reqAccept) begin
        pcF <= pcF + 32'd4;
      end
      if (reqAccept) tagWr <= tagWr + PTR_ONE;
      if (respTake)  tagRd <= tagRd + PTR_ONE;
      case ({reqAccept, respTake})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tag FIFO storage: remember PC and epoch of each accepted request
  always_ff @(posedge clk) begin
    if (reqAccept) begin
      tagPc[tagWr]    <= pcF;
      tagEpoch[tagWr] <= epoch;
    end
  end

  // Fetch queue pointers and occupancy; a redirect discards all buffered words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fqWr    <= '0;
      fqRd    <= '0;
      fqCount <= '0;
    end else if (PCSrcE_i) begin
      fqWr    <= '0;
      fqRd    <= '0;
      fqCount <= '0;
    end else begin
      if (respFresh) fqWr <= fqWr + PTR_ONE;
      if (fqPop)     fqRd <= fqRd + PTR_ONE;
      case ({respFresh, fqPop})
        2'b10:   fqCount <= fqCount + CNT_ONE;
        2'b01:   fqCount <= fqCount - CNT_ONE;
        default: fqCount <= fqCount;
      endcase
    end
  end

  // Fetch queue storage: fresh words paired with the PC they were fetched from
  always_ff @(posedge clk) begin
    if (respFresh) begin
      fqData[fqWr] <= ImemRespData_i;
      fqPc[fqWr]   <= tagPc[tagRd];
    end
  end

  // A fresh word must find a free slot, or one freed by a same-cycle pop
  always_ff @(posedge clk) begin
    if (reset && respFresh && !fqPop) assert (!fqFull);
  end

  // IF/ID register: flush/redirect beats stall, stall beats pop, empty queue gives a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= '0;
      PCPlus4D_o <= '0;
      ValidD_o   <= 1'b0;
    end else if (bubbleD) begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= '0;
      PCPlus4D_o <= '0;
      ValidD_o   <= 1'b0;
    end else if (StallD_i) begin
      InstrD_o   <= InstrD_o;
      PCD_o      <= PCD_o;
      PCPlus4D_o <= PCPlus4D_o;
      ValidD_o   <= ValidD_o;
    end else if (!fqEmpty) begin
      InstrD_o   <= fqData[fqRd];
      PCD_o      <= fqPc[fqRd];
      PCPlus4D_o <= fqPc[fqRd] + 32'd4;
      ValidD_o   <= 1'b1;
    end else begin
      InstrD_o   <= NOP_INSTR;
      PCD_o      <= '0;
      PCPlus4D_o <= '0;
      ValidD_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_unit.sv
// Bench for ucsbece154b_fetch_unit: a behavioural in-order memory with
// programmable latency, a PC model that predicts every request address, and a
// scoreboard of PCs expected to reach decode.
module tb_ucsbece154b_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ImemReqReady = 1'b1;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = '0;
  logic        ImemReqValid;
  logic [31:0] ImemReqAddr;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchEmpty;

  ucsbece154b_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .StallF_i        (StallF),
    .StallD_i        (StallD),
    .FlushD_i        (FlushD),
    .PCSrcE_i        (PCSrcE),
    .PCTargetE_i     (PCTargetE),
    .ImemReqValid_o  (ImemReqValid),
    .ImemReqReady_i  (ImemReqReady),
    .ImemReqAddr_o   (ImemReqAddr),
    .ImemRespValid_i (ImemRespValid),
    .ImemRespData_i  (ImemRespData),
    .InstrD_o        (InstrD),
    .PCD_o           (PCD),
    .PCPlus4D_o      (PCPlus4D),
    .ValidD_o        (ValidD),
    .FetchEmpty_o    (FetchEmpty)
  );

  // Scoreboard and model state
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          memLat = 1;
  int          edgeN = 0;
  int          nDeliv = 0;
  logic [31:0] tbPc = RESET_PC;
  logic [31:0] lastPc = '0;
  logic [31:0] firstPc = '0;
  logic        capFirst = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes, clock, update memory/PC models, check IF/ID
  task automatic step();
    logic        acc;
    logic [31:0] accAddr;
    logic        respUsed;
    logic        deliverOk;
    logic        flushEdge;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e;
    #1;
    acc       = reset && ImemReqValid && ImemReqReady;
    accAddr   = ImemReqAddr;
    respUsed  = ImemRespValid;
    deliverOk = reset && !FlushD && !PCSrcE && !StallD;
    flushEdge = reset && (FlushD || PCSrcE);
    redir     = reset && PCSrcE;
    tgt       = PCTargetE;
    @(posedge clk);
    edgeN++;
    #1;
    if (respUsed) begin
      e = mem_addr_q.pop_front();
      void'(mem_due_q.pop_front());
    end
    if (acc) begin
      check("req_addr", accAddr, tbPc);
      mem_addr_q.push_back(tbPc);
      mem_due_q.push_back(edgeN + memLat);
      exp_q.push_back(tbPc);
      tbPc = tbPc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      tbPc = tgt;
    end
    if (flushEdge) begin
      check("bubble_validD", {31'b0, ValidD}, 32'd0);
      check("bubble_instrD", InstrD, NOP);
      check("bubble_pcD", PCD, 32'd0);
      check("bubble_pcplus4D", PCPlus4D, 32'd0);
    end
    if (deliverOk && ValidD) begin
      if (exp_q.size() == 0) begin
        check("spurious_validD", {31'b0, ValidD}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("deliver_pcD", PCD, e);
        check("deliver_instrD", InstrD, memWord(e));
        check("deliver_pcplus4D", PCPlus4D, e + 32'd4);
        lastPc = e;
        nDeliv++;
        if (capFirst) begin
          firstPc  = PCD;
          capFirst = 1'b0;
        end
      end
    end
    if (mem_due_q.size() != 0 && mem_due_q[0] <= edgeN + 1) begin
      ImemRespValid = 1'b1;
      ImemRespData  = memWord(mem_addr_q[0]);
    end else begin
      ImemRespValid = 1'b0;
      ImemRespData  = '0;
    end
  endtask

  // Stop fetching and let every accepted request reach decode
  task automatic drain();
    StallF = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && mem_due_q.size() == 0) break;
      step();
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_instrD"}, InstrD, NOP);
    check({tag, "_pcD"}, PCD, 32'd0);
    check({tag, "_pcplus4D"}, PCPlus4D, 32'd0);
    check({tag, "_validD"}, {31'b0, ValidD}, 32'd0);
    check({tag, "_req_valid"}, {31'b0, ImemReqValid}, 32'd0);
    check({tag, "_req_addr"}, ImemReqAddr, RESET_PC);
    check({tag, "_fetch_empty"}, {31'b0, FetchEmpty}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    checkResetValues("reset");
    reset = 1'b1;

    // 1: zero-wait memory, no stalls
    memLat = 1; ImemReqReady = 1'b1; StallF = 1'b0; nDeliv = 0;
    repeat (12) step();
    check("t1_enough_deliveries", {31'b0, nDeliv >= 6}, 32'd1);
    drain();

    // 2: memory not ready for 5 cycles
    ImemReqReady = 1'b0; StallF = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_req_valid", {31'b0, ImemReqValid}, 32'd1);
      check("t2_req_addr_held", ImemReqAddr, tbPc);
      check("t2_validD", {31'b0, ValidD}, 32'd0);
      check("t2_instrD", InstrD, NOP);
    end
    ImemReqReady = 1'b1;
    repeat (6) step();
    drain();

    // 3: redirect with two requests in flight
    memLat = 3; StallF = 1'b0;
    step();
    step();
    check("t3_no_credit", {31'b0, ImemReqValid}, 32'd0);
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
    step();
    PCSrcE = 1'b0;
    step();
    check("t3_stale1_dropped", {31'b0, FetchEmpty}, 32'd1);
    step();
    check("t3_stale2_dropped", {31'b0, FetchEmpty}, 32'd1);
    capFirst = 1'b1;
    repeat (10) step();
    check("t3_first_pc", firstPc, 32'h0000_0100);
    drain();

    // 4: StallD with the queue full, then 5: StallD and FlushD together
    memLat = 1; StallF = 1'b0; StallD = 1'b0; nDeliv = 0;
    for (int i = 0; i < 10 && nDeliv == 0; i++) step();
    check("t4_first_delivery", 32'(nDeliv), 32'd1);
    StallD = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_pcD", PCD, lastPc);
      check("t4_hold_instrD", InstrD, memWord(lastPc));
      check("t4_hold_pcplus4D", PCPlus4D, lastPc + 32'd4);
      check("t4_hold_validD", {31'b0, ValidD}, 32'd1);
      check("t4_req_valid", {31'b0, ImemReqValid}, 32'd0);
      check("t4_queue_nonempty", {31'b0, FetchEmpty}, 32'd0);
    end
    FlushD = 1'b1;
    step();
    FlushD = 1'b0;
    check("t5_queue_kept", {31'b0, FetchEmpty}, 32'd0);
    check("t5_queue_left", 32'(exp_q.size()), 32'd2);
    StallD = 1'b0;
    drain();

    // 6: reset asserted with one request outstanding
    memLat = 3; StallF = 1'b0;
    step();
    StallF = 1'b1;
    reset = 1'b0;
    #1;
    checkResetValues("t6_async");
    exp_q.delete();
    tbPc = RESET_PC;
    step();
    reset = 1'b1;
    step();
    step();
    check("t6_late_dropped", {31'b0, FetchEmpty}, 32'd1);
    check("t6_validD", {31'b0, ValidD}, 32'd0);
    StallF = 1'b0; capFirst = 1'b1;
    repeat (10) step();
    check("t6_first_pc", firstPc, RESET_PC);
    drain();

    // 7: PC wrap with random memory latency and readiness
    StallF = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    step();
    PCSrcE = 1'b0; nDeliv = 0;
    for (int i = 0; i < 16; i++) begin
      memLat = $urandom_range(1, 3);
      ImemReqReady = 1'($urandom_range(0, 1));
      step();
    end
    memLat = 1; ImemReqReady = 1'b1;
    repeat (6) step();
    drain();
    check("t7_wrap_deliveries", {31'b0, nDeliv >= 3}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
